// File: rtl/cache_ctrl_pkg.sv
// Shared types and constants for the per-bank cache miss controller:
// FSM state encoding, victim-word field layout and a one-hot test.
package cache_ctrl_pkg;

  localparam int SET_CNT   = 4;
  localparam int BLOCK_CNT = 6;
  localparam int DOSA      = 4;
  localparam int ADDR_W    = SET_CNT + BLOCK_CNT;
  localparam int VICTIM_W  = 2 * SET_CNT + 2;

  // Victim word layout: {Valid, Dirty, Way, Set}
  localparam int VALID_BIT = VICTIM_W - 1;
  localparam int DIRTY_BIT = VICTIM_W - 2;
  localparam int WAY_LSB   = SET_CNT;
  localparam int SET_LSB   = 0;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_LOOKUP,
    ST_HIT_UPD,
    ST_VICTIM,
    ST_VIC_CAP,
    ST_WB_REQ,
    ST_WB_WAIT,
    ST_RF_REQ,
    ST_RF_WAIT,
    ST_DONE
  } state_e;

  function automatic logic is_onehot(input logic [DOSA-1:0] v);
    return (v != '0) && ((v & (v - DOSA'(1))) == '0);
  endfunction

endpackage

// File: rtl/cache_perf_cnt.sv
// Saturating hit / miss / write-back event counters for the miss controller.
// Only instantiated when CACHE_PERF_CNT_EN is defined.
module cache_perf_cnt (
  input  logic        clk,
  input  logic        RST,
  input  logic        hit_inc_i,
  input  logic        miss_inc_i,
  input  logic        wb_inc_i,
  output logic [31:0] hit_cnt_o,
  output logic [31:0] miss_cnt_o,
  output logic [31:0] wb_cnt_o
);

  logic [31:0] hit_q, hit_d;
  logic [31:0] miss_q, miss_d;
  logic [31:0] wb_q, wb_d;

  // Counters hold at all-ones instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] c, input logic inc);
    return (inc && (c != '1)) ? c + 32'd1 : c;
  endfunction

  always_comb begin
    hit_d  = sat_inc(hit_q, hit_inc_i);
    miss_d = sat_inc(miss_q, miss_inc_i);
    wb_d   = sat_inc(wb_q, wb_inc_i);
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      hit_q  <= '0;
      miss_q <= '0;
      wb_q   <= '0;
    end else begin
      hit_q  <= hit_d;
      miss_q <= miss_d;
      wb_q   <= wb_d;
    end
  end

  assign hit_cnt_o  = hit_q;
  assign miss_cnt_o = miss_q;
  assign wb_cnt_o   = wb_q;

endmodule

// File: rtl/cache_miss_ctrl.sv
// Per-bank miss controller: LRU lookup/update strobes, victim write-back and refill.
// Define CACHE_PERF_CNT_EN to add hit_cnt / miss_cnt / wb_cnt counter outputs.
module cache_miss_ctrl
  import cache_ctrl_pkg::*;
(
  input  logic                  clk,
  input  logic                  RST,
  input  logic                  pe_req,
  input  logic                  pe_rd_wr,
  input  logic [ADDR_W-1:0]     pe_addr,
  output logic                  pe_ack,
  input  logic                  tag_hit,
  input  logic [DOSA-1:0]       tag_hit_x,
  output logic                  peEN_3,
  output logic                  Rd_Wr,
  output logic [DOSA-1:0]       hit_x,
  output logic                  HIT,
  output logic [BLOCK_CNT-1:0]  Index_pe,
  output logic                  memEN,
  output logic [ADDR_W-1:0]     Set_Index_mem,
  input  logic [VICTIM_W-1:0]   Least_used_lru,
  output logic                  mem_req,
  output logic                  mem_wr,
  output logic [ADDR_W-1:0]     mem_addr,
  input  logic                  mem_gnt,
  input  logic                  mem_done,
  output logic                  busy
`ifdef CACHE_PERF_CNT_EN
  ,
  output logic [31:0]           hit_cnt,
  output logic [31:0]           miss_cnt,
  output logic [31:0]           wb_cnt
`endif
);

  state_e                state_q, state_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic                  rd_wr_q, rd_wr_d;
  logic [BLOCK_CNT-1:0]  index_q, index_d;
  logic [ADDR_W-1:0]     set_idx_q, set_idx_d;
  logic [ADDR_W-1:0]     mem_addr_q, mem_addr_d;
  logic [SET_CNT-1:0]    way_q, way_d;
  logic                  hit_q, hit_d;
  logic [DOSA-1:0]       hit_x_q, hit_x_d;
  logic                  rdwr_out_q, rdwr_out_d;
  logic                  pe_ack_q, peen_q, memen_q, mem_req_q, mem_wr_q, busy_q;
  logic                  lookup_hit;
  logic                  refill_done;

  assign lookup_hit = tag_hit && is_onehot(tag_hit_x);

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    rd_wr_d     = rd_wr_q;
    index_d     = index_q;
    set_idx_d   = set_idx_q;
    mem_addr_d  = mem_addr_q;
    way_d       = way_q;
    hit_d       = hit_q;
    hit_x_d     = hit_x_q;
    rdwr_out_d  = rdwr_out_q;
    refill_done = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (pe_req) begin
          addr_d  = pe_addr;
          rd_wr_d = pe_rd_wr;
          index_d = pe_addr[BLOCK_CNT-1:0];
          state_d = ST_LOOKUP;
        end
      end
      ST_LOOKUP: begin
        hit_d      = lookup_hit;
        hit_x_d    = lookup_hit ? tag_hit_x : '0;
        rdwr_out_d = rd_wr_q;
        if (lookup_hit) begin
          state_d = ST_HIT_UPD;
        end else begin
          set_idx_d = addr_q;
          state_d   = ST_VICTIM;
        end
      end
      ST_HIT_UPD: state_d = ST_DONE;
      ST_VICTIM:  state_d = ST_VIC_CAP;
      ST_VIC_CAP: begin
        way_d = Least_used_lru[WAY_LSB +: SET_CNT];
        if (Least_used_lru[VALID_BIT] && Least_used_lru[DIRTY_BIT]) begin
          mem_addr_d = {Least_used_lru[SET_LSB +: SET_CNT], addr_q[BLOCK_CNT-1:0]};
          state_d    = ST_WB_REQ;
        end else begin
          mem_addr_d = addr_q;
          state_d    = ST_RF_REQ;
        end
      end
      ST_WB_REQ: begin
        if (mem_gnt) begin
          if (mem_done) begin
            mem_addr_d = addr_q;
            state_d    = ST_RF_REQ;
          end else begin
            state_d = ST_WB_WAIT;
          end
        end
      end
      ST_WB_WAIT: begin
        if (mem_done) begin
          mem_addr_d = addr_q;
          state_d    = ST_RF_REQ;
        end
      end
      ST_RF_REQ: begin
        if (mem_gnt) begin
          if (mem_done) refill_done = 1'b1;
          else          state_d = ST_RF_WAIT;
        end
      end
      ST_RF_WAIT: begin
        if (mem_done) refill_done = 1'b1;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // A write miss ends with a hit update on the refilled way so the LRU marks it dirty.
    if (refill_done) begin
      if (!rd_wr_q) begin
        hit_d      = 1'b1;
        hit_x_d    = DOSA'(1) << way_q;
        rdwr_out_d = 1'b0;
        state_d    = ST_HIT_UPD;
      end else begin
        state_d = ST_DONE;
      end
    end
  end

  // Strobes are registered from the next state so they line up with the state they belong to.
  always_ff @(posedge clk) begin
    if (RST) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      rd_wr_q    <= 1'b0;
      index_q    <= '0;
      set_idx_q  <= '0;
      mem_addr_q <= '0;
      way_q      <= '0;
      hit_q      <= 1'b0;
      hit_x_q    <= '0;
      rdwr_out_q <= 1'b0;
      pe_ack_q   <= 1'b0;
      peen_q     <= 1'b0;
      memen_q    <= 1'b0;
      mem_req_q  <= 1'b0;
      mem_wr_q   <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      rd_wr_q    <= rd_wr_d;
      index_q    <= index_d;
      set_idx_q  <= set_idx_d;
      mem_addr_q <= mem_addr_d;
      way_q      <= way_d;
      hit_q      <= hit_d;
      hit_x_q    <= hit_x_d;
      rdwr_out_q <= rdwr_out_d;
      pe_ack_q   <= (state_d == ST_DONE);
      peen_q     <= (state_d == ST_HIT_UPD);
      memen_q    <= (state_d == ST_VICTIM);
      mem_req_q  <= (state_d == ST_WB_REQ) || (state_d == ST_RF_REQ);
      mem_wr_q   <= (state_d == ST_WB_REQ);
      busy_q     <= (state_d != ST_IDLE);
    end
  end

  assign pe_ack        = pe_ack_q;
  assign peEN_3        = peen_q;
  assign Rd_Wr         = rdwr_out_q;
  assign hit_x         = hit_x_q;
  assign HIT           = hit_q;
  assign Index_pe      = index_q;
  assign memEN         = memen_q;
  assign Set_Index_mem = set_idx_q;
  assign mem_req       = mem_req_q;
  assign mem_wr        = mem_wr_q;
  assign mem_addr      = mem_addr_q;
  assign busy          = busy_q;

`ifdef CACHE_PERF_CNT_EN
  logic hit_inc, miss_inc, wb_inc;

  assign hit_inc  = (state_q == ST_LOOKUP) && (state_d == ST_HIT_UPD);
  assign miss_inc = (state_q != ST_VICTIM) && (state_d == ST_VICTIM);
  assign wb_inc   = (state_q != ST_WB_REQ) && (state_d == ST_WB_REQ);

  cache_perf_cnt u_perf_cnt (
    .clk        (clk),
    .RST        (RST),
    .hit_inc_i  (hit_inc),
    .miss_inc_i (miss_inc),
    .wb_inc_i   (wb_inc),
    .hit_cnt_o  (hit_cnt),
    .miss_cnt_o (miss_cnt),
    .wb_cnt_o   (wb_cnt)
  );
`endif

endmodule

// File: doc/cache_miss_ctrl.md
Name: cache_miss_ctrl

Overview:
- Per-bank miss-handling controller that sequences the LRU replacement array and the external memory port.
- Takes one PE request at a time and issues the LRU lookup/update strobes (peEN, memEN, Set_Index_mem).
- Reads the returned victim word {Valid, Dirty, Way, Set}. On a dirty victim it runs a write-back, then a refill, then releases the PE.
- Sits between the PE request port, the tag-compare stage and the DDR/DMA memory interface.

Parameters:
- SET_CNT, 4, bits of set/tag field per entry; also width of the way-id field.
- BLOCK_CNT, 6, index bits; cache depth = 2**BLOCK_CNT.
- DOSA, 4, ways per index; hit vector width (one-hot).
- VICTIM_W, 2*SET_CNT+2, victim word width: bit[VICTIM_W-1]=Valid, [VICTIM_W-2]=Dirty, [2*SET_CNT-1:SET_CNT]=Way, [SET_CNT-1:0]=Set.

Ports:
- clk  in  1  clock.
- RST  in  1  synchronous active-high reset.
- pe_req  in  1  PE request valid.
- pe_rd_wr  in  1  1=read, 0=write.
- pe_addr  in  SET_CNT+BLOCK_CNT  {Set, Index}.
- pe_ack  out  1  one-cycle request-complete pulse.
- tag_hit  in  1  tag-compare hit; valid in LOOKUP only.
- tag_hit_x  in  DOSA  one-hot hit way.
- peEN_3  out  1  LRU hit-update strobe.
- Rd_Wr  out  1  registered pe_rd_wr to the LRU.
- hit_x  out  DOSA  registered tag_hit_x.
- HIT  out  1  registered tag_hit.
- Index_pe  out  BLOCK_CNT  index to the LRU.
- memEN  out  1  LRU victim-pop strobe.
- Set_Index_mem  out  SET_CNT+BLOCK_CNT  address for the victim pop.
- Least_used_lru  in  VICTIM_W  victim word; valid 1 cycle after memEN.
- mem_req  out  1  memory command valid.
- mem_wr  out  1  1=write-back, 0=refill.
- mem_addr  out  SET_CNT+BLOCK_CNT  {Set, Index} of the memory transfer.
- mem_gnt  in  1  command accepted.
- mem_done  in  1  transfer complete pulse.
- busy  out  1  FSM not IDLE.

Behaviour:
- Reset (synchronous, RST=1 at posedge):
  - State goes to IDLE.
  - All outputs are 0: pe_ack, peEN_3, memEN, mem_req, mem_wr, busy, HIT, hit_x, Rd_Wr, Index_pe, Set_Index_mem, mem_addr.
  - A reset mid-transfer abandons the transfer. The memory side must also be reset.
- States: IDLE, LOOKUP, HIT_UPD, VICTIM, VIC_CAP, WB_REQ, WB_WAIT, RF_REQ, RF_WAIT, DONE.
- IDLE:
  - On pe_req=1, latch pe_addr and pe_rd_wr, drive Index_pe = pe_addr index, go to LOOKUP.
  - pe_req is ignored while busy=1. The PE must hold pe_req until pe_ack.
- LOOKUP (1 cycle): register tag_hit into HIT, tag_hit_x into hit_x, and pe_rd_wr into Rd_Wr.
  - tag_hit=1 goes to HIT_UPD.
  - tag_hit=0 goes to VICTIM.
  - tag_hit=1 with tag_hit_x not one-hot is treated as a miss.
- HIT_UPD: peEN_3=1 for exactly 1 cycle, go to DONE.
  - The LRU applies the update 2 cycles later. The next IDLE acceptance is no earlier than that, so back-to-back requests to the same index see the updated order.
- VICTIM: memEN=1 for exactly 1 cycle, Set_Index_mem = latched address, go to VIC_CAP.
- VIC_CAP: capture Least_used_lru.
  - Valid=1 and Dirty=1: go to WB_REQ, mem_addr = {victim Set, Index}.
  - Otherwise: go to RF_REQ, mem_addr = latched address.
- WB_REQ / RF_REQ:
  - Hold mem_req=1; mem_wr=1 in WB_REQ, 0 in RF_REQ.
  - Drop mem_req on the cycle after mem_gnt=1, then go to the matching WAIT state.
  - No timeout.
- WB_WAIT: on mem_done go to RF_REQ with mem_addr = latched address.
- RF_WAIT: on mem_done go to DONE.
  - A write miss is a refill followed by a hit update: RF_WAIT then HIT_UPD with HIT=1 and hit_x = one-hot of the victim Way, so the LRU sets the Dirty bit for writes.
  - The HIT_UPD that follows a refill goes to DONE.
- DONE: pe_ack=1 for 1 cycle, go to IDLE.
- Simultaneous events:
  - mem_gnt and mem_done in the same cycle in a REQ state: both are honoured, skipping WAIT.
  - mem_done outside a WAIT state is ignored.
- Latency:
  - Hit: 4 cycles, req to pe_ack.
  - Clean miss: 6 + memory cycles.
  - Dirty miss: adds one write-back.

Optional Feature:
- CACHE_PERF_CNT_EN defined: adds three 32-bit saturating counters, each an output port.
  - hit_cnt: +1 on entering HIT_UPD from LOOKUP.
  - miss_cnt: +1 on entering VICTIM.
  - wb_cnt: +1 on entering WB_REQ.
  - All clear on RST. Counters do not wrap; they hold at 32'hFFFF_FFFF.
- Undefined: no counter ports, no counter logic.

Decomposition:
- Package cache_ctrl_pkg holds:
  - the state enum;
  - VICTIM_W;
  - victim field offsets (VALID_BIT, DIRTY_BIT, WAY_LSB, SET_LSB);
  - a one-hot-check function.
- One sub-module: cache_perf_cnt, instantiated only under CACHE_PERF_CNT_EN.

Test Plan:
- Reset, then read hit: pe_addr={4'h3,6'h05}, tag_hit=1, tag_hit_x=4'b0100 -> peEN_3 pulses once with hit_x=4'b0100, Rd_Wr=1; pe_ack 4 cycles after req; mem_req never asserted.
- Clean miss: victim=Valid 0 -> memEN pulse with Set_Index_mem={4'h3,6'h05}; one refill mem_req with mem_wr=0, mem_addr={4'h3,6'h05}; pe_ack after mem_done.
- Dirty miss: victim Valid=1, Dirty=1, Set=4'hA, Way=2 -> write-back mem_addr={4'hA,6'h05} with mem_wr=1 first; refill {4'h3,6'h05} only after WB mem_done.
- Write miss: pe_rd_wr=0, clean victim Way=1 -> after refill, peEN_3 with HIT=1, hit_x=4'b0010, Rd_Wr=0.
- mem_gnt and mem_done together in RF_REQ -> goes directly to DONE; pe_ack 1 cycle later; exactly one mem_req handshake.
- RST asserted in WB_WAIT -> next cycle IDLE, all outputs 0. A new hit request then completes normally. With CACHE_PERF_CNT_EN, the counters read 0.
